// File: rtl/peripheral_pkg.sv
// Shared opcodes, response codes, FSM encoding and status-word layout for the
// peripheral responder.
package peripheral_pkg;

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_READ   = 2'b10;
    localparam logic [1:0] OP_STATUS = 2'b11;

    localparam logic [1:0] RSP_NONE   = 2'b00;
    localparam logic [1:0] RSP_ACK    = 2'b01;
    localparam logic [1:0] RSP_DATA   = 2'b10;
    localparam logic [1:0] RSP_STATUS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RESPOND = 2'd1,
        ST_WAIT    = 2'd2
    } state_t;

    // Status word: [7:0] output count, [15:8] input count, [16] drop, [17] timeout.
    localparam int STAT_OCNT_LSB    = 0;
    localparam int STAT_ICNT_LSB    = 8;
    localparam int STAT_DROP_BIT    = 16;
    localparam int STAT_TIMEOUT_BIT = 17;

endpackage

// File: rtl/peripheral_sync_fifo.sv
// Synchronous FIFO with registered count and wrap-around pointers; no bypass,
// so a word pushed at one edge is visible at the head from the next edge.
module peripheral_sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        i_push,
    input  logic [DATA_WIDTH-1:0]       i_push_data,
    input  logic                        i_pop,
    output logic [DATA_WIDTH-1:0]       o_head,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [$clog2(DEPTH):0]      o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    // A push into a full FIFO is dropped even if a pop happens in the same cycle.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/peripheral_responder.sv
// Peripheral endpoint of the core's 2-bit opcode I/O channel: WRITE/READ/STATUS
// requests served from an output FIFO (to host) and an input FIFO (from host).
module peripheral_responder
    import peripheral_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            to_peripheral,
    input  logic [DATA_WIDTH-1:0] to_peripheral_data,
    input  logic                  to_peripheral_valid,
    output logic [1:0]            from_peripheral,
    output logic [DATA_WIDTH-1:0] from_peripheral_data,
    output logic                  from_peripheral_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [TW-1:0]         r_timer;
    logic [TW-1:0]         w_timer_next;
    logic [1:0]            r_pend_op;
    logic [DATA_WIDTH-1:0] r_pend_data;
    logic [1:0]            r_code;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_drop_sticky;
    logic                  r_timeout_sticky;
    logic [1:0]            r_rsp_code;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_valid;

    logic                  w_req;
    logic [1:0]            w_op;
    logic [DATA_WIDTH-1:0] w_op_data;
    logic                  w_is_write;
    logic                  w_can_do;
    logic [DATA_WIDTH-1:0] w_status;
    logic                  w_out_push;
    logic                  w_in_pop;
    logic                  w_load;
    logic [1:0]            w_code_next;
    logic [DATA_WIDTH-1:0] w_data_next;
    logic                  w_latch;
    logic                  w_clear_sticky;
    logic                  w_set_drop;
    logic                  w_set_timeout;

    logic [DATA_WIDTH-1:0] w_out_head;
    logic                  w_out_full;
    logic                  w_out_empty;
    logic [CW-1:0]         w_out_count;
    logic [DATA_WIDTH-1:0] w_in_head;
    logic                  w_in_full;
    logic                  w_in_empty;
    logic [CW-1:0]         w_in_count;

    peripheral_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_out_fifo (
        .clock       (clock),
        .reset       (reset),
        .i_push      (w_out_push),
        .i_push_data (w_op_data),
        .i_pop       (out_ready),
        .o_head      (w_out_head),
        .o_full      (w_out_full),
        .o_empty     (w_out_empty),
        .o_count     (w_out_count)
    );

    peripheral_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_in_fifo (
        .clock       (clock),
        .reset       (reset),
        .i_push      (in_valid),
        .i_push_data (in_data),
        .i_pop       (w_in_pop),
        .o_head      (w_in_head),
        .o_full      (w_in_full),
        .o_empty     (w_in_empty),
        .o_count     (w_in_count)
    );

    assign out_data  = w_out_head;
    assign out_valid = !w_out_empty;
    assign in_ready  = !w_in_full;

    assign from_peripheral       = r_rsp_code;
    assign from_peripheral_data  = r_rsp_data;
    assign from_peripheral_valid = r_rsp_valid;

    // In WAIT the latched request is retried instead of the live bus.
    assign w_req      = to_peripheral_valid && (to_peripheral != OP_NOP);
    assign w_op       = (r_state == ST_WAIT) ? r_pend_op : to_peripheral;
    assign w_op_data  = (r_state == ST_WAIT) ? r_pend_data : to_peripheral_data;
    assign w_is_write = (w_op == OP_WRITE);
    assign w_can_do   = (w_is_write && !w_out_full) || ((w_op == OP_READ) && !w_in_empty);

    always_comb begin
        w_status = '0;
        w_status[STAT_OCNT_LSB +: 8] = 8'(w_out_count);
        w_status[STAT_ICNT_LSB +: 8] = 8'(w_in_count);
        w_status[STAT_DROP_BIT]      = r_drop_sticky;
        w_status[STAT_TIMEOUT_BIT]   = r_timeout_sticky;
    end

    always_comb begin
        w_state_next   = r_state;
        w_timer_next   = r_timer;
        w_out_push     = 1'b0;
        w_in_pop       = 1'b0;
        w_load         = 1'b0;
        w_code_next    = RSP_NONE;
        w_data_next    = '0;
        w_latch        = 1'b0;
        w_clear_sticky = 1'b0;
        w_set_drop     = 1'b0;
        w_set_timeout  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    if (to_peripheral == OP_STATUS) begin
                        w_state_next   = ST_RESPOND;
                        w_load         = 1'b1;
                        w_code_next    = RSP_STATUS;
                        w_data_next    = w_status;
                        w_clear_sticky = 1'b1;
                    end else if (w_can_do) begin
                        w_state_next = ST_RESPOND;
                        w_load       = 1'b1;
                        w_out_push   = w_is_write;
                        w_in_pop     = !w_is_write;
                        w_code_next  = w_is_write ? RSP_ACK : RSP_DATA;
                        w_data_next  = w_is_write ? w_op_data : w_in_head;
                    end else begin
                        w_state_next = ST_WAIT;
                        w_latch      = 1'b1;
                        w_timer_next = '0;
                    end
                end
            end
            ST_WAIT: begin
                w_set_drop = w_req;
                if (w_can_do) begin
                    w_state_next = ST_RESPOND;
                    w_load       = 1'b1;
                    w_out_push   = w_is_write;
                    w_in_pop     = !w_is_write;
                    w_code_next  = w_is_write ? RSP_ACK : RSP_DATA;
                    w_data_next  = w_is_write ? w_op_data : w_in_head;
                end else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    // Timed-out request is discarded; the status reply already shows the timeout.
                    w_state_next  = ST_RESPOND;
                    w_load        = 1'b1;
                    w_set_timeout = 1'b1;
                    w_code_next   = RSP_STATUS;
                    w_data_next   = w_status;
                    w_data_next[STAT_TIMEOUT_BIT] = 1'b1;
                end else begin
                    w_timer_next = r_timer + TW'(1);
                end
            end
            ST_RESPOND: begin
                w_set_drop   = w_req;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state          <= ST_IDLE;
            r_timer          <= '0;
            r_pend_op        <= OP_NOP;
            r_pend_data      <= '0;
            r_code           <= RSP_NONE;
            r_data           <= '0;
            r_drop_sticky    <= 1'b0;
            r_timeout_sticky <= 1'b0;
            r_rsp_code       <= RSP_NONE;
            r_rsp_data       <= '0;
            r_rsp_valid      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
            if (w_latch) begin
                r_pend_op   <= to_peripheral;
                r_pend_data <= to_peripheral_data;
            end
            if (w_load) begin
                r_code <= w_code_next;
                r_data <= w_data_next;
            end
            if (w_clear_sticky) begin
                r_drop_sticky    <= 1'b0;
                r_timeout_sticky <= 1'b0;
            end
            if (w_set_drop) begin
                r_drop_sticky <= 1'b1;
            end
            if (w_set_timeout) begin
                r_timeout_sticky <= 1'b1;
            end
            // The response register drives the bus for the one cycle after RESPOND.
            r_rsp_valid <= (r_state == ST_RESPOND);
            r_rsp_code  <= (r_state == ST_RESPOND) ? r_code : RSP_NONE;
            r_rsp_data  <= (r_state == ST_RESPOND) ? r_data : '0;
        end
    end

endmodule

// File: tb/tb_peripheral_responder.sv
// Directed bench for peripheral_responder: request/response codes, FIFO paths,
// WAIT completion, timeout, drop flag and reset during WAIT.
module tb_peripheral_responder;

    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic [1:0]    to_peripheral;
    logic [DW-1:0] to_peripheral_data;
    logic          to_peripheral_valid;
    logic [1:0]    from_peripheral;
    logic [DW-1:0] from_peripheral_data;
    logic          from_peripheral_valid;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;

    int n_checks = 0;
    int n_errors = 0;

    peripheral_responder #(.DATA_WIDTH(DW), .FIFO_DEPTH(8), .TIMEOUT_CYCLES(16)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .to_peripheral         (to_peripheral),
        .to_peripheral_data    (to_peripheral_data),
        .to_peripheral_valid   (to_peripheral_valid),
        .from_peripheral       (from_peripheral),
        .from_peripheral_data  (from_peripheral_data),
        .from_peripheral_valid (from_peripheral_valid),
        .out_data              (out_data),
        .out_valid             (out_valid),
        .out_ready             (out_ready),
        .in_data               (in_data),
        .in_valid              (in_valid),
        .in_ready              (in_ready)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic send_req(input logic [1:0] op, input logic [DW-1:0] data);
        to_peripheral_valid = 1'b1;
        to_peripheral       = op;
        to_peripheral_data  = data;
        tick();
        to_peripheral_valid = 1'b0;
        to_peripheral       = 2'b00;
        to_peripheral_data  = '0;
    endtask

    task automatic host_push(input logic [DW-1:0] data);
        in_valid = 1'b1;
        in_data  = data;
        tick();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Waits for the response pulse; exp_wait > 0 also pins the cycle count.
    task automatic expect_rsp(input string tag, input logic [1:0] exp_code,
                              input logic [DW-1:0] exp_data, input int exp_wait,
                              input int max_wait);
        int  waited = 0;
        bit  seen   = 1'b0;
        while (!seen && waited < max_wait) begin
            tick();
            waited++;
            if (from_peripheral_valid) seen = 1'b1;
        end
        chk({tag, "_seen"}, DW'(seen), DW'(1));
        if (seen) begin
            if (exp_wait > 0) chk({tag, "_latency"}, DW'(waited), DW'(exp_wait));
            chk({tag, "_code"}, DW'(from_peripheral), DW'(exp_code));
            chk({tag, "_data"}, from_peripheral_data, exp_data);
            tick();
            chk({tag, "_pulse_end"}, DW'(from_peripheral_valid), DW'(0));
            chk({tag, "_code_idle"}, DW'(from_peripheral), DW'(0));
        end
    endtask

    initial begin
        int quiet;

        reset               = 1'b0;
        to_peripheral       = 2'b00;
        to_peripheral_data  = '0;
        to_peripheral_valid = 1'b0;
        out_ready           = 1'b0;
        in_data             = '0;
        in_valid            = 1'b0;

        // Reset state
        repeat (3) @(negedge clock);
        reset = 1'b1;
        chk("rst_code",  DW'(from_peripheral), DW'(0));
        chk("rst_valid", DW'(from_peripheral_valid), DW'(0));
        chk("rst_data",  from_peripheral_data, 32'h0);
        chk("rst_out_valid", DW'(out_valid), DW'(0));
        chk("rst_in_ready",  DW'(in_ready), DW'(1));

        // WRITE echo, then host pops the word
        send_req(2'b01, 32'hDEADBEEF);
        expect_rsp("wr1", 2'b01, 32'hDEADBEEF, 1, 10);
        chk("wr1_out_valid", DW'(out_valid), DW'(1));
        chk("wr1_out_data",  out_data, 32'hDEADBEEF);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("wr1_popped", DW'(out_valid), DW'(0));

        // Two host words read back in order
        host_push(32'h00001000);
        host_push(32'h80000000);
        chk("rd_in_ready_a", DW'(in_ready), DW'(1));
        send_req(2'b10, '0);
        expect_rsp("rd1", 2'b10, 32'h00001000, 1, 10);
        send_req(2'b10, '0);
        expect_rsp("rd2", 2'b10, 32'h80000000, 1, 10);
        chk("rd_in_ready_b", DW'(in_ready), DW'(1));

        // READ waits for a late host push; no timeout
        send_req(2'b10, '0);
        quiet = 0;
        repeat (4) begin
            tick();
            if (from_peripheral_valid) quiet++;
        end
        chk("wait_quiet", DW'(quiet), DW'(0));
        host_push(32'hFFFFF000);
        expect_rsp("rd_wait", 2'b10, 32'hFFFFF000, 2, 10);

        // READ with no data times out after 16 WAIT cycles
        send_req(2'b10, '0);
        expect_rsp("timeout", 2'b11, 32'h00020000, 17, 40);
        send_req(2'b11, '0);
        expect_rsp("stat_to1", 2'b11, 32'h00020000, 1, 10);
        send_req(2'b11, '0);
        expect_rsp("stat_to2", 2'b11, 32'h00000000, 1, 10);

        // Fill the output FIFO
        for (int i = 0; i < 8; i++) begin
            send_req(2'b01, 32'hA0000000 + DW'(i));
            expect_rsp("fill", 2'b01, 32'hA0000000 + DW'(i), 1, 10);
        end
        send_req(2'b11, '0);
        expect_rsp("stat_full", 2'b11, 32'h00000008, 1, 10);

        // Ninth WRITE stalls until the host pops
        send_req(2'b01, 32'hCAFE0009);
        quiet = 0;
        repeat (2) begin
            tick();
            if (from_peripheral_valid) quiet++;
        end
        chk("full_quiet", DW'(quiet), DW'(0));
        chk("full_head", out_data, 32'hA0000000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("full_head_next", out_data, 32'hA0000001);
        expect_rsp("wr9", 2'b01, 32'hCAFE0009, 0, 10);
        send_req(2'b11, '0);
        expect_rsp("stat_wr9", 2'b11, 32'h00000008, 1, 10);

        // Request during RESPOND is dropped and flagged
        send_req(2'b11, '0);
        send_req(2'b11, '0);
        chk("drop_rsp_valid", DW'(from_peripheral_valid), DW'(1));
        chk("drop_rsp_code",  DW'(from_peripheral), DW'(2'b11));
        chk("drop_rsp_data",  from_peripheral_data, 32'h00000008);
        quiet = 0;
        repeat (4) begin
            tick();
            if (from_peripheral_valid) quiet++;
        end
        chk("drop_no_extra", DW'(quiet), DW'(0));
        send_req(2'b11, '0);
        expect_rsp("stat_drop", 2'b11, 32'h00010008, 1, 10);
        send_req(2'b11, '0);
        expect_rsp("stat_drop_clr", 2'b11, 32'h00000008, 1, 10);

        // Reset while a WRITE waits on the full output FIFO
        host_push(32'h00000055);
        send_req(2'b01, 32'h00000BAD);
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        chk("rw_code",      DW'(from_peripheral), DW'(0));
        chk("rw_valid",     DW'(from_peripheral_valid), DW'(0));
        chk("rw_data",      from_peripheral_data, 32'h0);
        chk("rw_out_valid", DW'(out_valid), DW'(0));
        chk("rw_in_ready",  DW'(in_ready), DW'(1));
        quiet = 0;
        repeat (20) begin
            tick();
            if (from_peripheral_valid) quiet++;
        end
        chk("rw_no_rsp", DW'(quiet), DW'(0));
        send_req(2'b11, '0);
        expect_rsp("stat_after_rst", 2'b11, 32'h00000000, 1, 10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
